// File: rtl/det1010_pkg.sv
// Shared state encodings for the 1010 detector scheduler.
package det1010_pkg;

   // Top-level scheduler FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      REPORT = 2'b10
   } sched_state_t;

   // Overlapping 1010 Mealy detector states.
   typedef enum logic [1:0] {
      S0   = 2'b00,
      S1   = 2'b01,
      S10  = 2'b10,
      S101 = 2'b11
   } det_state_t;

endpackage

// File: rtl/det1010_scheduler_seq_det_1010.sv
// Overlapping "1010" Mealy detector with synchronous clear and advance enable.
module seq_det_1010
   import det1010_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic x,
   output logic y
);

   det_state_t r_state;

   // Advance the detector on enabled bits; clr restarts it for a new word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S0;
      end else if (clr) begin
         r_state <= S0;
      end else if (en) begin
         case (r_state)
            S0:      r_state <= x ? S1   : S0;
            S1:      r_state <= x ? S1   : S10;
            S10:     r_state <= x ? S101 : S0;
            S101:    r_state <= x ? S1   : S10;
            default: r_state <= S0;
         endcase
      end
   end

   // Mealy hit: the closing 0 of 1010 while bits are being fed.
   always_comb begin
      y = en && (r_state == S101) && !x;
   end

endmodule

// File: rtl/det1010_scheduler.sv
// Round-robin scheduler feeding two requesters' words MSB-first into a
// shared 1010 detector and reporting the per-word match count.
module det1010_scheduler
   import det1010_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [CW-1:0]    count,
   output logic             serial_x,
   output logic             det_y
);

   localparam int unsigned BW = $clog2(WIDTH);

   sched_state_t     r_state;
   logic [WIDTH-1:0] r_shift;
   logic [BW-1:0]    r_bitcnt;
   logic [CW-1:0]    r_count;
   logic [1:0]       r_gnt;
   logic             r_busy;
   logic             r_done;
   logic             r_done_id;
   logic             r_last;
   logic             r_id;

   logic             w_shifting;
   logic             w_grant;
   logic             w_sel;
   logic             w_x;
   logic             w_y;

   // Arbitration and the serial bit presented to the detector.
   always_comb begin
      w_shifting = (r_state == SHIFT);
      w_grant    = (r_state == IDLE) && (req0 || req1);
      // On a tie the requester that was not served last wins.
      w_sel      = req1 && (!req0 || !r_last);
      w_x        = w_shifting ? r_shift[WIDTH-1] : 1'b0;
   end

   seq_det_1010 u_det (
      .clk   (clk),
      .reset (reset),
      .clr   (w_grant),
      .en    (w_shifting),
      .x     (w_x),
      .y     (w_y)
   );

   // Scheduler FSM with registered grant, busy and done outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bitcnt  <= '0;
         r_count   <= '0;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_done_id <= 1'b0;
         r_last    <= 1'b1;
         r_id      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_shift  <= w_sel ? data1 : data0;
                  r_gnt    <= w_sel ? 2'b10 : 2'b01;
                  r_id     <= w_sel;
                  r_count  <= '0;
                  r_bitcnt <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
               r_bitcnt <= r_bitcnt + 1'b1;
               if (w_y) begin
                  r_count <= r_count + 1'b1;
               end
               if (r_bitcnt == BW'(WIDTH - 1)) begin
                  r_gnt     <= '0;
                  r_done    <= 1'b1;
                  r_done_id <= r_id;
                  r_state   <= REPORT;
               end
            end
            REPORT: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_last  <= r_id;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Drive ports from registered state and the detector output.
   always_comb begin
      gnt      = r_gnt;
      busy     = r_busy;
      done     = r_done;
      done_id  = r_done_id;
      count    = r_count;
      serial_x = w_x;
      det_y    = w_y;
   end

endmodule
